fc_mac_array: RTL and testbench

Parametrised successor to full_connect: a fully-connected-layer MAC engine for signed fixed-point data, LANES-wide.
- Streams (fin, wgt) vector beats plus one bias per output channel through a valid/ready handshake.
- Accumulates each output channel over a configurable number of beats, then requantises with shift, optional ReLU and saturation.
- Emits one result per output channel on a backpressurable valid/ready output.
- Sits between the fin/weight buffer readers and the fout write-back.

---
 rtl/fc_pkg.sv | 28 ++
 rtl/fc_lane_mult_sum.sv | 56 +++++
 rtl/fc_mac_array.sv | 165 ++++++++++++++++
 tb/tb_fc_mac_array.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types, defaults and helpers for the fully-connected MAC array.
package fc_pkg;

  localparam int DEF_LANES  = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_OUT_W  = 16;
  localparam int DEF_IDX_W  = 12;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fc_state_e;

  // Width of an exact sum of LANES signed DATA_W x DATA_W products.
  function automatic int lane_sum_w(input int lanes, input int data_w);
    return 2 * data_w + $clog2(lanes);
  endfunction

  // Clamp a signed value to the range of a signed out_w-bit number.
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fc_lane_mult_sum.sv
// S1 of the MAC pipe: registered per-lane products and beat flags, with the
// lane adder tree reading the registered products.
module fc_lane_mult_sum
  import fc_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    en,
  input  logic                                    in_vld,
  input  logic                                    in_first,
  input  logic                                    in_last,
  input  logic [LANES*DATA_W-1:0]                 fin,
  input  logic [LANES*DATA_W-1:0]                 wgt,
  output logic                                    s1_vld,
  output logic                                    s1_first,
  output logic                                    s1_last,
  output logic signed [lane_sum_w(LANES, DATA_W)-1:0] sum
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = lane_sum_w(LANES, DATA_W);

  logic signed [PROD_W-1:0] prod_q [LANES];

  // NOTE: registered state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else if (en) begin
      s1_vld   <= in_vld;
      s1_first <= in_first;
      s1_last  <= in_last;
    end
  end

  // NOTE: product registers carry no reset; s1_vld qualifies them.
  always_ff @(posedge clk) begin
    if (en && in_vld) begin
      for (int i = 0; i < LANES; i++) begin
        prod_q[i] <= PROD_W'($signed(fin[i*DATA_W +: DATA_W])) *
                     PROD_W'($signed(wgt[i*DATA_W +: DATA_W]));
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) sum = sum + SUM_W'(prod_q[i]);
  end

endmodule

// File: rtl/fc_mac_array.sv
// Fully-connected-layer MAC engine: streams fin/wgt beats, accumulates each
// output channel from its bias, then requantises onto a valid/ready output.
module fc_mac_array
  import fc_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic [IDX_W-1:0]        cfg_fin_beats,
  input  logic [IDX_W-1:0]        cfg_fout_len,
  input  logic [5:0]              cfg_shift,
  input  logic                    cfg_relu,
  output logic                    busy,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [LANES*DATA_W-1:0] in_fin,
  input  logic [LANES*DATA_W-1:0] in_wgt,
  input  logic [ACC_W-1:0]        in_bias,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [OUT_W-1:0]        out_data,
  output logic [IDX_W-1:0]        out_fout_idx,
  output logic                    done
);

  localparam int SUM_W = lane_sum_w(LANES, DATA_W);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  fc_state_e         state;
  logic [IDX_W-1:0]  beats_q, fout_q, beat_cnt, ch_cnt, res_idx;
  logic [5:0]        shift_q;
  logic              relu_q;

  logic stall, en, accept, pop, start_ok, first_beat, last_beat, last_ch;

  assign stall      = out_vld && !out_rdy;
  assign en         = !stall;
  assign in_rdy     = (state == RUN) && !stall;
  assign accept     = in_vld && in_rdy;
  assign pop        = out_vld && out_rdy;
  assign start_ok   = (state == IDLE) && cfg_start && (cfg_fin_beats != '0) && (cfg_fout_len != '0);
  assign first_beat = (beat_cnt == '0);
  assign last_beat  = (beat_cnt == beats_q - IDX_ONE);
  assign last_ch    = (ch_cnt == fout_q - IDX_ONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      beat_cnt <= '0;
      ch_cnt   <= '0;
      beats_q  <= '0;
      fout_q   <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start_ok) begin
          beats_q  <= cfg_fin_beats;
          fout_q   <= cfg_fout_len;
          shift_q  <= cfg_shift;
          relu_q   <= cfg_relu;
          beat_cnt <= '0;
          ch_cnt   <= '0;
          busy     <= 1'b1;
          state    <= RUN;
        end
        RUN: if (accept) begin
          if (last_beat) begin
            beat_cnt <= '0;
            if (last_ch) state <= DRAIN;
            else         ch_cnt <= ch_cnt + IDX_ONE;
          end else begin
            beat_cnt <= beat_cnt + IDX_ONE;
          end
        end
        DRAIN: if (pop && (out_fout_idx == fout_q - IDX_ONE)) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic                    s1_vld, s1_first, s1_last;
  logic signed [SUM_W-1:0] s1_sum;
  logic signed [ACC_W-1:0] s1_bias, sum_ext;

  fc_lane_mult_sum #(.LANES(LANES), .DATA_W(DATA_W)) u_mult_sum (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_vld   (accept),
    .in_first (first_beat),
    .in_last  (last_beat),
    .fin      (in_fin),
    .wgt      (in_wgt),
    .s1_vld   (s1_vld),
    .s1_first (s1_first),
    .s1_last  (s1_last),
    .sum      (s1_sum)
  );

  // Bias rides alongside S1 so it lines up with the channel's first beat.
  always_ff @(posedge clk) begin
    if (accept && first_beat) s1_bias <= $signed(in_bias);
  end

  assign sum_ext = ACC_W'(s1_sum);

  logic signed [ACC_W-1:0] acc;
  logic                    acc_vld, acc_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_vld  <= 1'b0;
      acc_last <= 1'b0;
      acc      <= '0;
    end else if (en) begin
      acc_vld  <= s1_vld;
      acc_last <= s1_vld && s1_last;
      if (s1_vld) acc <= (s1_first ? s1_bias : acc) + sum_ext;
    end
  end

  logic signed [ACC_W-1:0] shifted;
  logic [OUT_W-1:0]        q_data;

  // NOTE: every always_comb output gets a value on all paths, so no latch.
  always_comb begin
    shifted = acc >>> shift_q;
    if (relu_q && shifted[ACC_W-1]) shifted = '0;
    q_data = OUT_W'(sat_clip(64'(shifted), OUT_W));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld      <= 1'b0;
      out_data     <= '0;
      out_fout_idx <= '0;
      res_idx      <= '0;
    end else begin
      if (start_ok) res_idx <= '0;
      if (en && acc_vld && acc_last) begin
        out_vld      <= 1'b1;
        out_data     <= q_data;
        out_fout_idx <= res_idx;
        res_idx      <= res_idx + IDX_ONE;
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fc_mac_array.sv
// Directed self-checking bench for fc_mac_array (LANES=4, 16-bit data).
module tb_fc_mac_array;
  import fc_pkg::*;

  localparam int LANES = 4, DATA_W = 16, ACC_W = 40, OUT_W = 16, IDX_W = 12;

  logic                    clk = 1'b0;
  logic                    rst_n, cfg_start, cfg_relu, in_vld, out_rdy;
  logic [IDX_W-1:0]        cfg_fin_beats, cfg_fout_len;
  logic [5:0]              cfg_shift;
  logic [LANES*DATA_W-1:0] in_fin, in_wgt;
  logic [ACC_W-1:0]        in_bias;
  logic                    busy, in_rdy, out_vld, done;
  logic [OUT_W-1:0]        out_data;
  logic [IDX_W-1:0]        out_fout_idx;

  fc_mac_array #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_fin_beats(cfg_fin_beats),
    .cfg_fout_len(cfg_fout_len), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .busy(busy),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_fin(in_fin), .in_wgt(in_wgt), .in_bias(in_bias),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_fout_idx(out_fout_idx),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [IDX_W-1:0] idx;
  } res_t;

  typedef struct {
    logic [63:0] fin;
    logic [63:0] wgt;
    logic [39:0] bias;
    logic [5:0]  shift;
    logic        relu;
    logic [15:0] exp;
  } vec_t;

  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, done_cnt = 0, done_at_pops = 0, last_rise = 0;
  logic prev_vld = 1'b0;
  res_t res_q[$];

  always @(posedge clk) cyc++;

  // Records every output handshake and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_vld && out_rdy) res_q.push_back('{out_data, out_fout_idx});
    if (done) begin
      done_cnt++;
      done_at_pops = res_q.size();
    end
    if (out_vld && !prev_vld) last_rise = cyc;
    prev_vld = out_vld;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
  endfunction

  function automatic logic [63:0] pk4(input int a);
    return pk(a, a, a, a);
  endfunction

  task automatic start_job(input int beats, input int fout, input int shift, input bit relu);
    cfg_fin_beats = IDX_W'(beats);
    cfg_fout_len  = IDX_W'(fout);
    cfg_shift     = 6'(shift);
    cfg_relu      = relu;
    cfg_start     = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] f, input logic [63:0] w, input logic [39:0] b,
                           output int t);
    bit ok = 1'b0;
    t      = 0;
    in_vld = 1'b1; in_fin = f; in_wgt = w; in_bias = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_rdy) begin
        ok = 1'b1;
        t  = cyc;
      end
      @(posedge clk); #1;
    end
    in_vld = 1'b0;
    if (!ok) check("in_rdy timeout", 0, 1);
  endtask

  task automatic wait_results(input int n, input int budget);
    for (int i = 0; i < budget && res_q.size() < n; i++) @(negedge clk);
    check("result count", res_q.size(), n);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int base, dbase, t;
    base  = res_q.size();
    dbase = done_cnt;
    start_job(1, 1, int'(v.shift), v.relu);
    send_beat(v.fin, v.wgt, v.bias, t);
    wait_results(base + 1, 50);
    repeat (2) @(negedge clk);
    if (res_q.size() > base) begin
      check($sformatf("vec%0d data", k), longint'($signed(res_q[base].data)), longint'($signed(v.exp)));
      check($sformatf("vec%0d idx", k), res_q[base].idx, 0);
    end
    check($sformatf("vec%0d done", k), done_cnt - dbase, 1);
    @(posedge clk); #1;
  endtask

  vec_t vecs[10];
  int   base, dbase, t, tt;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{pk(1, 2, 3, 4),            pk(5, 6, 7, 8),    40'(10),      6'(0),  1'b0, 16'(80)};
    vecs[1] = '{pk4(0),                    pk4(0),            40'(-100),    6'(2),  1'b0, 16'(-25)};
    vecs[2] = '{pk4(0),                    pk4(0),            40'(-100),    6'(2),  1'b1, 16'(0)};
    vecs[3] = '{pk4(0),                    pk4(0),            40'(200000),  6'(0),  1'b0, 16'(32767)};
    vecs[4] = '{pk4(0),                    pk4(0),            40'(-200000), 6'(0),  1'b0, 16'(-32768)};
    vecs[5] = '{pk4(0),                    pk4(0),            40'(-101),    6'(2),  1'b0, 16'(-26)};
    vecs[6] = '{pk(-3, 4, -5, 6),          pk(7, -8, 9, 10),  40'(0),       6'(1),  1'b0, 16'(-19)};
    vecs[7] = '{pk4(32767),                pk4(32767),        40'(0),       6'(16), 1'b1, 16'(32767)};
    vecs[8] = '{pk4(-32768),               pk4(32767),        40'(0),       6'(20), 1'b0, 16'(-4096)};
    vecs[9] = '{pk4(0),                    pk4(0),            40'(7),       6'(0),  1'b1, 16'(7)};

    rst_n = 1'b0; cfg_start = 1'b0; cfg_relu = 1'b0; cfg_shift = '0;
    cfg_fin_beats = '0; cfg_fout_len = '0; in_vld = 1'b0; out_rdy = 1'b1;
    in_fin = '0; in_wgt = '0; in_bias = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset in_rdy", in_rdy, 0);
    check("reset out_vld", out_vld, 0);
    check("reset done", done, 0);
    check("reset out_data", out_data, 0);
    check("reset out_idx", out_fout_idx, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single channel with latency and done/busy checks.
    base = res_q.size(); dbase = done_cnt;
    start_job(1, 1, 0, 1'b0);
    @(negedge clk);
    check("t1 busy after start", busy, 1);
    @(posedge clk); #1;
    send_beat(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 40'(10), t);
    wait_results(base + 1, 50);
    repeat (2) @(negedge clk);
    check("t1 latency", last_rise - t, 3);
    if (res_q.size() > base) begin
      check("t1 data", res_q[base].data, 80);
      check("t1 idx", res_q[base].idx, 0);
    end
    check("t1 done count", done_cnt - dbase, 1);
    check("t1 busy after done", busy, 0);
    @(posedge clk); #1;

    // Requantise / saturation / ReLU table.
    for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

    // Multi-beat, multi-channel; bias only from each channel's first beat.
    base = res_q.size(); dbase = done_cnt;
    start_job(3, 2, 0, 1'b0);
    for (int c = 0; c < 2; c++)
      for (int b = 0; b < 3; b++)
        send_beat(pk4(1), pk4(2), (b == 0) ? 40'(-5) : 40'(999), t);
    wait_results(base + 2, 50);
    repeat (2) @(negedge clk);
    for (int c = 0; c < 2 && base + c < res_q.size(); c++) begin
      check($sformatf("t2 data ch%0d", c), res_q[base+c].data, 19);
      check($sformatf("t2 idx ch%0d", c), res_q[base+c].idx, c);
    end
    check("t2 done count", done_cnt - dbase, 1);
    @(posedge clk); #1;

    // Backpressure: out_rdy low for 10 cycles mid-run.
    base = res_q.size(); dbase = done_cnt;
    start_job(2, 4, 0, 1'b0);
    fork
      begin
        for (int c = 0; c < 4; c++)
          for (int b = 0; b < 2; b++)
            send_beat(pk4(c + 1), pk4(3), (b == 0) ? 40'(100 * c) : 40'(999), tt);
      end
      begin
        repeat (3) @(posedge clk); #1;
        out_rdy = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("t4 stalled out_vld", out_vld, 1);
        check("t4 stalled in_rdy", in_rdy, 0);
        check("t4 no done while stalled", done_cnt - dbase, 0);
        @(posedge clk); #1;
        repeat (2) @(posedge clk); #1;
        out_rdy = 1'b1;
      end
    join
    wait_results(base + 4, 100);
    repeat (2) @(negedge clk);
    for (int c = 0; c < 4 && base + c < res_q.size(); c++) begin
      check($sformatf("t4 data ch%0d", c), res_q[base+c].data, 24 * (c + 1) + 100 * c);
      check($sformatf("t4 idx ch%0d", c), res_q[base+c].idx, c);
    end
    check("t4 done count", done_cnt - dbase, 1);
    check("t4 done after last pop", done_at_pops, base + 4);
    @(posedge clk); #1;

    // Reset during channel 1 discards everything in flight.
    base = res_q.size(); dbase = done_cnt;
    start_job(2, 3, 0, 1'b0);
    send_beat(pk4(1), pk4(1), 40'(50), t);
    send_beat(pk4(1), pk4(1), 40'(999), t);
    send_beat(pk4(2), pk4(2), 40'(60), t);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5 busy after reset", busy, 0);
    check("t5 in_rdy after reset", in_rdy, 0);
    check("t5 out_vld after reset", out_vld, 0);
    check("t5 done after reset", done, 0);
    repeat (6) @(negedge clk);
    check("t5 no stale results", res_q.size() - base, 0);
    check("t5 no stale done", done_cnt - dbase, 0);
    @(posedge clk); #1;
    start_job(2, 1, 0, 1'b0);
    send_beat(pk4(1), pk4(1), 40'(3), t);
    send_beat(pk4(1), pk4(1), 40'(999), t);
    wait_results(base + 1, 50);
    repeat (2) @(negedge clk);
    if (res_q.size() > base) begin
      check("t5 fresh data", res_q[base].data, 11);
      check("t5 fresh idx", res_q[base].idx, 0);
    end
    check("t5 fresh done", done_cnt - dbase, 1);
    @(posedge clk); #1;

    // Zero-length starts are ignored.
    base = res_q.size(); dbase = done_cnt;
    start_job(0, 3, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("t6 beats=0 busy", busy, 0);
    check("t6 beats=0 in_rdy", in_rdy, 0);
    @(posedge clk); #1;
    start_job(3, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("t6 fout=0 busy", busy, 0);
    check("t6 zero starts no done", done_cnt - dbase, 0);
    @(posedge clk); #1;

    // A start during RUN must not disturb the running job.
    start_job(2, 1, 0, 1'b0);
    send_beat(pk4(1), pk4(1), 40'(0), t);
    start_job(1, 5, 3, 1'b1);
    @(negedge clk);
    check("t6 busy after run start", busy, 1);
    @(posedge clk); #1;
    send_beat(pk4(1), pk4(1), 40'(999), t);
    wait_results(base + 1, 50);
    repeat (4) @(negedge clk);
    if (res_q.size() > base) begin
      check("t6 run-start data", res_q[base].data, 8);
      check("t6 run-start idx", res_q[base].idx, 0);
    end
    check("t6 run-start result count", res_q.size() - base, 1);
    check("t6 run-start done", done_cnt - dbase, 1);
    check("t6 busy final", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
